// File: rtl/cpu_axil_data_bridge.sv
// CPU data-port to AXI4-Lite master bridge.
// Each accepted load/store becomes one AXI4-Lite transaction. Store data and
// strobes are shifted onto the addressed byte lanes. Load data is extracted
// from the addressed lane and sign- or zero-extended. Misaligned or illegal
// requests complete with an error and generate no bus activity.
//
// Handshake rule on every AXI channel: a transfer happens on the rising edge
// where valid and ready are both high. Once a valid is raised it stays high,
// with its payload stable, until that edge.
module cpu_axil_data_bridge #(
    parameter int ADDR_W         = 32,
    parameter bit RESP_ERR_CHECK = 1'b1
) (
    input  logic              aclk,
    input  logic              aresetn,
    // CPU data port
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_we,
    input  logic [1:0]        cpu_ld_size,
    input  logic              cpu_ld_unsigned,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              cpu_busy,
    // AXI write address channel
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    // AXI write data channel
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    // AXI write response channel
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    // AXI read address channel
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    // AXI read data channel
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERR     = 3'd1,
        S_WR      = 3'd2,
        S_WR_RESP = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_DATA = 3'd5
    } state_t;

    state_t            state_q;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic              unsigned_q;

    logic [1:0]        lane_d;
    logic              misaligned_d;
    logic [ADDR_W-1:0] word_addr_d;
    logic [31:0]       wdata_d;
    logic [3:0]        wstrb_d;
    logic [31:0]       rshift_d;
    logic [31:0]       rdata_d;
    logic              b_err_d;
    logic              r_err_d;

    // Only bit 1 of a response distinguishes OKAY/EXOKAY from SLVERR/DECERR.
    logic              unused_resp_lsbs;
    assign unused_resp_lsbs = m_bresp[0] ^ m_rresp[0];

    assign cpu_busy = (state_q != S_IDLE);
    assign b_err_d  = RESP_ERR_CHECK & m_bresp[1];
    assign r_err_d  = RESP_ERR_CHECK & m_rresp[1];

    // Decode the incoming request: lane placement and legality.
    always_comb begin
        lane_d       = cpu_addr[1:0];
        word_addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
        wdata_d      = cpu_wdata << {lane_d, 3'b000};
        wstrb_d      = cpu_we << lane_d;
        misaligned_d = 1'b0;
        if (cpu_we != 4'b0000) begin
            case (cpu_we)
                4'b0001: misaligned_d = 1'b0;
                4'b0011: misaligned_d = lane_d[0];
                4'b1111: misaligned_d = (lane_d != 2'b00);
                default: misaligned_d = 1'b1;
            endcase
        end else begin
            case (cpu_ld_size)
                2'b00:   misaligned_d = 1'b0;
                2'b01:   misaligned_d = lane_d[0];
                2'b10:   misaligned_d = (lane_d != 2'b00);
                default: misaligned_d = 1'b1;
            endcase
        end
    end

    // Pick the addressed byte/half out of the read beat and extend it.
    always_comb begin
        rshift_d = m_rdata >> {lane_q, 3'b000};
        case (size_q)
            2'b00: rdata_d = unsigned_q ? {24'h0, rshift_d[7:0]}
                                        : {{24{rshift_d[7]}}, rshift_d[7:0]};
            2'b01: rdata_d = unsigned_q ? {16'h0, rshift_d[15:0]}
                                        : {{16{rshift_d[15]}}, rshift_d[15:0]};
            default: rdata_d = m_rdata;
        endcase
    end

    // Request FSM with all CPU and AXI outputs registered.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            lane_q     <= 2'b00;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            cpu_rdata  <= '0;
            cpu_done   <= 1'b0;
            cpu_err    <= 1'b0;
            m_awaddr   <= '0;
            m_awvalid  <= 1'b0;
            m_wdata    <= '0;
            m_wstrb    <= '0;
            m_wvalid   <= 1'b0;
            m_bready   <= 1'b0;
            m_araddr   <= '0;
            m_arvalid  <= 1'b0;
            m_rready   <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            cpu_err  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_en) begin
                        lane_q     <= lane_d;
                        size_q     <= cpu_ld_size;
                        unsigned_q <= cpu_ld_unsigned;
                        if (misaligned_d) begin
                            state_q <= S_ERR;
                        end else if (cpu_we != 4'b0000) begin
                            state_q   <= S_WR;
                            m_awaddr  <= word_addr_d;
                            m_wdata   <= wdata_d;
                            m_wstrb   <= wstrb_d;
                            m_awvalid <= 1'b1;
                            m_wvalid  <= 1'b1;
                        end else begin
                            state_q   <= S_RD_ADDR;
                            m_araddr  <= word_addr_d;
                            m_arvalid <= 1'b1;
                        end
                    end
                end
                S_ERR: begin
                    cpu_done <= 1'b1;
                    cpu_err  <= 1'b1;
                    state_q  <= S_IDLE;
                end
                S_WR: begin
                    // AW and W retire independently; move on once both have.
                    if (m_awvalid && m_awready) m_awvalid <= 1'b0;
                    if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
                    if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
                        m_bready <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (m_bvalid) begin
                        m_bready <= 1'b0;
                        cpu_done <= 1'b1;
                        cpu_err  <= b_err_d;
                        state_q  <= S_IDLE;
                    end
                end
                S_RD_ADDR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state_q   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    // Load data is captured even when the slave reports an error.
                    if (m_rvalid) begin
                        m_rready  <= 1'b0;
                        cpu_rdata <= rdata_d;
                        cpu_done  <= 1'b1;
                        cpu_err   <= r_err_d;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_axil_data_bridge.sv
// Bench for cpu_axil_data_bridge: directed cases from the test plan followed
// by randomized loads/stores against a behavioural model, with an AXI slave
// that inserts configurable ready/response delays.
module tb_cpu_axil_data_bridge;

    localparam int ADDR_W = 32;

    // ---------------- clock / reset ----------------
    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [31:0]       cpu_wdata = '0;
    logic              cpu_en = 1'b0;
    logic [3:0]        cpu_we = '0;
    logic [1:0]        cpu_ld_size = '0;
    logic              cpu_ld_unsigned = 1'b0;
    logic [31:0]       cpu_rdata;
    logic              cpu_done, cpu_err, cpu_busy;
    logic [ADDR_W-1:0] m_awaddr, m_araddr;
    logic              m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;
    logic              m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
    logic              m_bvalid = 1'b0, m_rvalid = 1'b0;
    logic [1:0]        m_bresp = '0, m_rresp = '0;
    logic [31:0]       m_rdata = '0;

    cpu_axil_data_bridge #(.ADDR_W(ADDR_W), .RESP_ERR_CHECK(1'b1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_en(cpu_en), .cpu_we(cpu_we),
        .cpu_ld_size(cpu_ld_size), .cpu_ld_unsigned(cpu_ld_unsigned),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    // ---------------- scoreboard bookkeeping ----------------
    typedef struct {
        logic        is_load;
        logic        bad;
        logic [31:0] addr_al;
        logic [31:0] wdata_sh;
        logic [3:0]  strb;
        logic [31:0] rdata_ext;
        logic        err;
        int          acc_cyc;
    } txn_t;

    txn_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what a request must produce, from the bridge's rules.
    function automatic txn_t model(input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [3:0] we, input logic [1:0] size,
                                   input logic uns, input logic [31:0] rdata,
                                   input logic [1:0] resp);
        txn_t        t;
        int unsigned l;
        logic [31:0] v;
        logic [7:0]  s8;
        l = addr % 4;
        t.is_load = (we == 4'd0);
        if (!t.is_load)
            t.bad = !((we == 4'd1) || (we == 4'd3 && l % 2 == 0) || (we == 4'd15 && l == 0));
        else
            t.bad = (size == 2'd3) || (size == 2'd1 && l % 2 == 1) || (size == 2'd2 && l != 0);
        t.addr_al  = addr - l;
        t.wdata_sh = wdata << (8 * l);
        s8         = {4'b0, we} << l;
        t.strb     = s8[3:0];
        v = rdata >> (8 * l);
        if (size == 2'd0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (size == 2'd1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end
        t.rdata_ext = v;
        t.err       = t.bad || resp[1];
        t.acc_cyc   = 0;
        return t;
    endfunction

    // ---------------- AXI slave ----------------
    int unsigned cfg_awd = 0, cfg_wd = 0, cfg_bd = 0, cfg_ard = 0, cfg_rd = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_resp  = '0;
    int unsigned aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic        aw_got, w_got, ar_got, hs_aw, hs_w, hs_b, hs_ar, hs_r;

    // Readies and responses change on the falling edge; hs_* remember what
    // will transfer on the next rising edge and are retired one cycle later.
    always @(negedge aclk) begin
        if (!aresetn) begin
            m_awready = 0; m_wready = 0; m_arready = 0;
            m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
        end else begin
            if (hs_aw) aw_got = 1;
            if (hs_w)  w_got  = 1;
            if (hs_ar) ar_got = 1;
            if (hs_b) begin m_bvalid = 0; aw_got = 0; w_got = 0; b_wait = 0; end
            if (hs_r) begin m_rvalid = 0; ar_got = 0; r_wait = 0; end
            if (m_awvalid) begin m_awready = (aw_wait >= cfg_awd); aw_wait++; end
            else begin m_awready = 0; aw_wait = 0; end
            if (m_wvalid) begin m_wready = (w_wait >= cfg_wd); w_wait++; end
            else begin m_wready = 0; w_wait = 0; end
            if (m_arvalid) begin m_arready = (ar_wait >= cfg_ard); ar_wait++; end
            else begin m_arready = 0; ar_wait = 0; end
            if (aw_got && w_got && !m_bvalid) begin
                if (b_wait >= cfg_bd) begin m_bvalid = 1; m_bresp = cfg_resp; end
                else b_wait++;
            end
            if (ar_got && !m_rvalid) begin
                if (r_wait >= cfg_rd) begin m_rvalid = 1; m_rdata = cfg_rdata; m_rresp = cfg_resp; end
                else r_wait++;
            end
            hs_aw = m_awvalid && m_awready;
            hs_w  = m_wvalid && m_wready;
            hs_ar = m_arvalid && m_arready;
            hs_b  = m_bvalid && m_bready;
            hs_r  = m_rvalid && m_rready;
        end
    end

    // ---------------- compare process ----------------
    logic [31:0] model_rdata = '0;
    logic        prev_done = 0, prev_aw_pend = 0, prev_w_pend = 0, prev_ar_pend = 0;
    int          aw_cyc = 0, w_cyc = 0, ar_cyc = 0, aw_hs = 0, w_hs = 0, ar_hs = 0;
    int          last_lat = 0, last_aw_cyc = 0, last_w_cyc = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
    logic [3:0]  last_wstrb = '0;
    logic        last_err = 0;
    txn_t        ct;

    always @(negedge aclk) begin
        #2;
        if (!aresetn) begin
            model_rdata = '0;
            prev_done = 0; prev_aw_pend = 0; prev_w_pend = 0; prev_ar_pend = 0;
            aw_cyc = 0; w_cyc = 0; ar_cyc = 0; aw_hs = 0; w_hs = 0; ar_hs = 0;
        end else begin
            if (prev_aw_pend) check("awvalid_held", m_awvalid, 1);
            if (prev_w_pend)  check("wvalid_held", m_wvalid, 1);
            if (prev_ar_pend) check("arvalid_held", m_arvalid, 1);
            if (m_awvalid) aw_cyc++;
            if (m_wvalid)  w_cyc++;
            if (m_arvalid) ar_cyc++;
            if (m_awvalid && m_awready) begin
                aw_hs++; last_awaddr = m_awaddr;
                if (exp_q.size() == 0) check("aw_without_request", 1, 0);
                else check("awaddr", m_awaddr, exp_q[0].addr_al);
            end
            if (m_wvalid && m_wready) begin
                w_hs++; last_wdata = m_wdata; last_wstrb = m_wstrb;
                if (exp_q.size() == 0) check("w_without_request", 1, 0);
                else begin
                    check("wdata", m_wdata, exp_q[0].wdata_sh);
                    check("wstrb", {28'h0, m_wstrb}, {28'h0, exp_q[0].strb});
                end
            end
            if (m_arvalid && m_arready) begin
                ar_hs++; last_araddr = m_araddr;
                if (exp_q.size() == 0) check("ar_without_request", 1, 0);
                else check("araddr", m_araddr, exp_q[0].addr_al);
            end
            check("cpu_busy", cpu_busy, (exp_q.size() != 0) && !cpu_done);
            if (cpu_done) begin
                check("done_back_to_back", prev_done, 0);
                if (exp_q.size() == 0) begin
                    check("done_without_request", 1, 0);
                end else begin
                    ct = exp_q.pop_front();
                    check("cpu_err", cpu_err, ct.err);
                    last_err = cpu_err;
                    last_lat = cyc - ct.acc_cyc;
                    if (ct.is_load && !ct.bad) model_rdata = ct.rdata_ext;
                    if (ct.bad) begin
                        check("no_axi_on_misaligned", aw_cyc + w_cyc + ar_cyc, 0);
                    end else if (ct.is_load) begin
                        check("ar_transfers", ar_hs, 1);
                        check("write_on_load", aw_hs + w_hs, 0);
                    end else begin
                        check("aw_transfers", aw_hs, 1);
                        check("w_transfers", w_hs, 1);
                        check("read_on_store", ar_hs, 0);
                    end
                end
                last_aw_cyc = aw_cyc; last_w_cyc = w_cyc;
                aw_cyc = 0; w_cyc = 0; ar_cyc = 0; aw_hs = 0; w_hs = 0; ar_hs = 0;
            end
            check("cpu_rdata", cpu_rdata, model_rdata);
            prev_done    = cpu_done;
            prev_aw_pend = m_awvalid && !m_awready;
            prev_w_pend  = m_wvalid && !m_wready;
            prev_ar_pend = m_arvalid && !m_arready;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_req(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] we, input logic [1:0] size, input logic uns,
                             input logic [31:0] rdata, input logic [1:0] resp,
                             input int unsigned awd, input int unsigned wd, input int unsigned bd,
                             input int unsigned ard, input int unsigned rd);
        txn_t t;
        cfg_awd = awd; cfg_wd = wd; cfg_bd = bd; cfg_ard = ard; cfg_rd = rd;
        cfg_rdata = rdata; cfg_resp = resp;
        t = model(addr, wdata, we, size, uns, rdata, resp);
        cpu_addr = addr; cpu_wdata = wdata; cpu_we = we;
        cpu_ld_size = size; cpu_ld_unsigned = uns; cpu_en = 1'b1;
        @(posedge aclk);
        #1;
        cpu_en = 1'b0;
        t.acc_cyc = cyc;
        exp_q.push_back(t);
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge aclk);
            #3;
            n++;
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] we, input logic [1:0] size, input logic uns,
                          input logic [31:0] rdata, input logic [1:0] resp,
                          input int unsigned awd, input int unsigned wd, input int unsigned bd,
                          input int unsigned ard, input int unsigned rd);
        start_req(addr, wdata, we, size, uns, rdata, resp, awd, wd, bd, ard, rd);
        wait_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdata"}, cpu_rdata, 0);
        check({tag, "_flags"}, {24'h0, cpu_done, cpu_err, cpu_busy, m_awvalid,
                                m_wvalid, m_bready, m_arvalid, m_rready}, 0);
        check({tag, "_awaddr"}, m_awaddr, 0);
        check({tag, "_araddr"}, m_araddr, 0);
        check({tag, "_wdata"}, m_wdata, 0);
        check({tag, "_wstrb"}, {28'h0, m_wstrb}, 0);
    endtask

    // ---------------- main sequence ----------------
    logic [3:0]  r_we;
    logic [1:0]  r_size, r_resp;
    logic [31:0] r_addr;
    int          wait_n;

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        check_reset_outputs("reset");
        @(negedge aclk);
        #4 aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // SW, all readies immediate
        do_req(32'h100, 32'hA5A5_1234, 4'b1111, 2'd0, 1'b0, 32'h0, 2'b00, 0, 0, 0, 0, 0);
        check("sw_awaddr", last_awaddr, 32'h100);
        check("sw_wdata", last_wdata, 32'hA5A5_1234);
        check("sw_wstrb", {28'h0, last_wstrb}, 32'hF);
        check("sw_latency", last_lat, 2);
        check("sw_err", last_err, 0);

        // SB to lane 3
        do_req(32'h203, 32'h0000_00EE, 4'b0001, 2'd0, 1'b0, 32'h0, 2'b00, 0, 0, 0, 0, 0);
        check("sb_awaddr", last_awaddr, 32'h200);
        check("sb_wdata", last_wdata, 32'hEE00_0000);
        check("sb_wstrb", {28'h0, last_wstrb}, 32'h8);

        // SB with awready late by 3 cycles, wready immediate
        do_req(32'h203, 32'h0000_00EE, 4'b0001, 2'd0, 1'b0, 32'h0, 2'b00, 3, 0, 0, 0, 0);
        check("sb_slow_aw_cycles", last_aw_cyc, 4);
        check("sb_slow_w_cycles", last_w_cyc, 1);

        // Loads
        do_req(32'h302, 32'h0, 4'b0000, 2'd0, 1'b0, 32'h1280_5634, 2'b00, 0, 0, 0, 0, 0);
        check("lb_signed", cpu_rdata, 32'hFFFF_FF80);
        check("lb_latency", last_lat, 2);
        check("lb_araddr", last_araddr, 32'h300);
        do_req(32'h302, 32'h0, 4'b0000, 2'd0, 1'b1, 32'h1280_5634, 2'b00, 0, 0, 0, 0, 0);
        check("lb_unsigned", cpu_rdata, 32'h0000_0080);
        do_req(32'h402, 32'h0, 4'b0000, 2'd1, 1'b0, 32'h8001_7FFF, 2'b00, 0, 0, 0, 0, 0);
        check("lh_signed", cpu_rdata, 32'hFFFF_8001);
        do_req(32'h404, 32'h0, 4'b0000, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 0, 0);
        check("lw_slverr_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("lw_slverr_err", last_err, 1);

        // Misaligned requests
        do_req(32'h102, 32'h1234_5678, 4'b1111, 2'd0, 1'b0, 32'h0, 2'b00, 0, 0, 0, 0, 0);
        check("sw_mis_err", last_err, 1);
        check("sw_mis_latency", last_lat, 1);
        check("sw_mis_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
        do_req(32'h101, 32'h0, 4'b0000, 2'd1, 1'b0, 32'h0, 2'b00, 0, 0, 0, 0, 0);
        check("lh_mis_err", last_err, 1);
        check("lh_mis_latency", last_lat, 1);

        // Reset while a read beat is being offered
        start_req(32'h500, 32'h0, 4'b0000, 2'd2, 1'b0, 32'h1111_2222, 2'b00, 0, 0, 0, 0, 3);
        wait_n = 0;
        while (!(m_rready && m_rvalid) && wait_n < 50) begin
            @(negedge aclk);
            #3;
            wait_n++;
        end
        check("rd_beat_pending", m_rready && m_rvalid, 1);
        #1 aresetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1;
        check("midreset_no_done", cpu_done, 0);
        @(negedge aclk);
        #4 aresetn = 1'b1;
        repeat (5) @(negedge aclk);
        do_req(32'h404, 32'h0, 4'b0000, 2'd2, 1'b0, 32'h1357_2468, 2'b00, 0, 0, 0, 0, 0);
        check("lw_after_reset", cpu_rdata, 32'h1357_2468);
        check("lw_after_reset_err", last_err, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    r_we = 4'b0000;
                2:       r_we = 4'b0001;
                3:       r_we = 4'b0011;
                4:       r_we = 4'b1111;
                default: r_we = 4'($urandom_range(0, 15));
            endcase
            r_addr = 32'h1000 + $urandom_range(0, 63);
            r_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_resp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            do_req(r_addr, $urandom, r_we, r_size, 1'($urandom_range(0, 1)), $urandom, r_resp,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));
            repeat ($urandom_range(0, 1)) @(negedge aclk);
        end
        repeat (5) @(negedge aclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
